// File: rtl/ram_scanout.sv
// Frame scanout: sweeps the 160x120 3-bit framebuffer RAM row-major and replays
// each pixel into the VGA pixel-write port. Optional: SCANOUT_SKIP_BLACK_EN.
module ram_scanout #(
    parameter int XMAX = 159,
    parameter int YMAX = 119
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        hold,
    output logic [14:0] rd_address,
    output logic        rd_req,
    input  logic [2:0]  rd_q,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] XLAST = 8'(XMAX);
    localparam logic [6:0] YLAST = 7'(YMAX);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        PLOT,
        FINISH
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  xc_reg, xc_next;
    logic [6:0]  yc_reg, yc_next;
    logic [2:0]  colour_reg, colour_next;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            xc_reg     <= '0;
            yc_reg     <= '0;
            colour_reg <= '0;
        end else begin
            state_reg  <= state_next;
            xc_reg     <= xc_next;
            yc_reg     <= yc_next;
            colour_reg <= colour_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        xc_next     = xc_reg;
        yc_next     = yc_reg;
        colour_next = colour_reg;
        rd_address  = '0;
        rd_req      = 1'b0;
        plot        = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    xc_next    = '0;
                    yc_next    = '0;
                    state_next = READ;
                end
            end

            READ: begin
                busy       = 1'b1;
                rd_address = {xc_reg, yc_reg};
                rd_req     = !hold;
                // The RAM samples our address at the edge that leaves READ.
                if (!hold) begin
                    state_next = CAPTURE;
                end
            end

            CAPTURE: begin
                busy        = 1'b1;
                colour_next = rd_q;
                state_next  = PLOT;
            end

            PLOT: begin
                busy = 1'b1;
`ifdef SCANOUT_SKIP_BLACK_EN
                plot = (colour_reg != 3'b000);
`else
                plot = 1'b1;
`endif
                if (xc_reg == XLAST && yc_reg == YLAST) begin
                    state_next = FINISH;
                end else if (xc_reg == XLAST) begin
                    xc_next    = '0;
                    yc_next    = yc_reg + 7'd1;
                    state_next = READ;
                end else begin
                    xc_next    = xc_reg + 8'd1;
                    state_next = READ;
                end
            end

            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign x      = xc_reg;
    assign y      = yc_reg;
    assign colour = colour_reg;

endmodule

// File: tb/tb_ram_scanout.sv
// Self-checking bench for ram_scanout: behavioural RAM, timeline model of the
// sweep (pixel order, plot/read cycles, hold stretching) and reset scenarios.
module tb_ram_scanout;

    logic        CLOCK_50;
    logic        resetn;
    logic        start;
    logic        hold;
    logic [14:0] rd_address;
    logic        rd_req;
    logic [2:0]  rd_q;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

`ifdef SCANOUT_SKIP_BLACK_EN
    localparam bit SKIP_BLACK = 1'b1;
`else
    localparam bit SKIP_BLACK = 1'b0;
`endif

    ram_scanout #(.XMAX(159), .YMAX(119)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .hold       (hold),
        .rd_address (rd_address),
        .rd_req     (rd_req),
        .rd_q       (rd_q),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Framebuffer RAM: registered read; returns junk when scanout is not addressing it.
    logic [2:0] mem [0:32767];
    always @(posedge CLOCK_50) begin
        if (rd_req) rd_q <= mem[rd_address];
        else        rd_q <= 3'($urandom);
    end

    typedef struct {int px; int py; int c; int cyc;} pix_t;
    typedef struct {int addr; int cyc;} read_t;

    pix_t  pix_q[$];
    read_t read_q[$];
    bit    hold_sched [0:65535];
    int    done_cyc;

    task automatic fill_mem();
        for (int a = 0; a < 32768; a++) mem[a] = 3'($urandom);
        mem[{8'd5, 7'd3}] = 3'b010;
        mem[{8'd7, 7'd7}] = 3'b100;
    endtask

    // Timeline model: a pixel's read waits out hold, then plots 2 cycles later.
    task automatic build_model();
        int t;
        pix_q.delete();
        read_q.delete();
        t = 1;
        for (int yy = 0; yy <= 119; yy++) begin
            for (int xx = 0; xx <= 159; xx++) begin
                int a;
                while (hold_sched[t]) t++;
                a = xx * 128 + yy;
                read_q.push_back('{addr: a, cyc: t});
                if (!(SKIP_BLACK && mem[a] == 3'b000))
                    pix_q.push_back('{px: xx, py: yy, c: int'(mem[a]), cyc: t + 2});
                t += 3;
            end
        end
        done_cyc = t;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        hold   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLOCK_50);
            #1;
            checks++;
            if ({rd_address, rd_req, x, y, colour, plot, busy, done} !== 37'd0) begin
                errors++;
                $display("FAIL reset_outputs got=%h required=0",
                         {rd_address, rd_req, x, y, colour, plot, busy, done});
            end
        end
        resetn = 1'b1;
        $display("test_reset complete");
    endtask

    task automatic test_reset_mid_sweep();
        fill_mem();
        @(posedge CLOCK_50);
        #1 start = 1'b1;
        hold = 1'b0;
        @(posedge CLOCK_50);
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            #1 start = 1'b0;
            #1;
            if (cyc == 3) begin
                checks++;
                if (!(plot === 1'b1 && x === 8'd0 && y === 7'd0 && colour === mem[0])) begin
                    errors++;
                    $display("FAIL pre_reset_first_plot got plot=%b x=%0d y=%0d c=%0d required plot=1 x=0 y=0 c=%0d",
                             plot, x, y, colour, mem[0]);
                end
            end
            if (cyc == 999) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid_sweep got=%b required=1", busy);
                end
            end
            if (cyc < 1000) @(posedge CLOCK_50);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({rd_address, rd_req, x, y, colour, plot, busy, done} !== 37'd0) begin
            errors++;
            $display("FAIL reset_mid_sweep_outputs got=%h required=0",
                     {rd_address, rd_req, x, y, colour, plot, busy, done});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge CLOCK_50);
            #2;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_held_quiet got done=%b busy=%b required 0 0", done, busy);
            end
        end
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50);
            #2;
            checks++;
            if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL no_resume got busy=%b plot=%b done=%b required 0 0 0", busy, plot, done);
            end
        end
        #1 start = 1'b1;
        @(posedge CLOCK_50);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            #1 start = 1'b0;
            #1;
            if (cyc == 3) begin
                checks++;
                if (!(plot === 1'b1 && x === 8'd0 && y === 7'd0 && colour === mem[0])) begin
                    errors++;
                    $display("FAIL restart_first_plot got plot=%b x=%0d y=%0d c=%0d required plot=1 x=0 y=0 c=%0d",
                             plot, x, y, colour, mem[0]);
                end
            end
            @(posedge CLOCK_50);
        end
        #1 resetn = 1'b0;
        #1 resetn = 1'b1;
        $display("test_reset_mid_sweep complete");
    endtask

    // Full frame with hold in cycles 1..10, random hold bursts later, and a
    // stray start pulse at cycle 500.
    task automatic test_full_frame();
        int done_cnt;
        int plot_cnt;
        int exp_plots;
        fill_mem();
        for (int i = 0; i < 65536; i++) hold_sched[i] = 1'b0;
        for (int i = 1; i <= 10; i++) hold_sched[i] = 1'b1;
        for (int i = 600; i < 56000; i++) begin
            if ($urandom_range(63, 0) == 0) begin
                int len;
                len = int'($urandom_range(3, 1));
                for (int k = 0; k < len; k++) hold_sched[i + k] = 1'b1;
                i += len;
            end
        end
        build_model();
        exp_plots = pix_q.size();
        done_cnt  = 0;
        plot_cnt  = 0;

        @(posedge CLOCK_50);
        #1 start = 1'b1;
        hold = 1'b0;
        @(posedge CLOCK_50);
        for (int cyc = 1; cyc <= done_cyc + 2; cyc++) begin
            #1;
            hold  = hold_sched[cyc];
            start = (cyc == 500);
            #1;
            if (cyc <= 10) begin
                checks++;
                if (rd_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_req_under_hold cyc=%0d got=%b required=0", cyc, rd_req);
                end
            end
            if (rd_req === 1'b1) begin
                read_t r;
                checks++;
                if (read_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_read cyc=%0d got addr=%h required no read", cyc, rd_address);
                end else begin
                    r = read_q.pop_front();
                    if (int'(rd_address) != r.addr || cyc != r.cyc) begin
                        errors++;
                        $display("FAIL read_addr got addr=%h cyc=%0d required addr=%h cyc=%0d",
                                 rd_address, cyc, r.addr, r.cyc);
                    end
                end
            end
            if (plot === 1'b1) begin
                pix_t p;
                plot_cnt++;
                checks++;
                if (pix_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_plot cyc=%0d got x=%0d y=%0d required no plot", cyc, x, y);
                end else begin
                    p = pix_q.pop_front();
                    if (int'(x) != p.px || int'(y) != p.py || int'(colour) != p.c || cyc != p.cyc) begin
                        errors++;
                        $display("FAIL plot got x=%0d y=%0d c=%0d cyc=%0d required x=%0d y=%0d c=%0d cyc=%0d",
                                 x, y, colour, cyc, p.px, p.py, p.c, p.cyc);
                    end
                end
                if (plot_cnt == 1) begin
                    checks++;
                    if (cyc != 13) begin
                        errors++;
                        $display("FAIL first_plot_cycle got=%0d required=13", cyc);
                    end
                end
                if (x === 8'd5 && y === 7'd3) begin
                    checks++;
                    if (colour !== 3'b010) begin
                        errors++;
                        $display("FAIL addr_5_3_colour got=%b required=010", colour);
                    end
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                checks++;
                if (cyc != done_cyc || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_timing got cyc=%0d busy=%b required cyc=%0d busy=0",
                             cyc, busy, done_cyc);
                end
            end
            if (cyc == done_cyc + 1) begin
                checks++;
                if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_after_done got busy=%b plot=%b done=%b required 0 0 0",
                             busy, plot, done);
                end
            end
            @(posedge CLOCK_50);
        end
        hold  = 1'b0;
        start = 1'b0;
        checks++;
        if (plot_cnt != exp_plots || pix_q.size() != 0) begin
            errors++;
            $display("FAIL plot_count got=%0d required=%0d", plot_cnt, exp_plots);
        end
        checks++;
        if (read_q.size() != 0) begin
            errors++;
            $display("FAIL read_count got missing=%0d required=0", read_q.size());
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_count got=%0d required=1", done_cnt);
        end
        $display("test_full_frame complete: %0d plots, done at cycle %0d", plot_cnt, done_cyc);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        hold   = 1'b0;
        test_reset();
        test_reset_mid_sweep();
        test_full_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
